response_logger: RTL
====================

# response_logger

Synthesizable capture block for the add4 adder test environment: the write-side counterpart of the stimulus reader. It watches the DUT result bus ({co, sum}) and waits until each new value has settled through the gate delays. Each settled change is recorded as a {timestamp, value} pair in a small first-word-fall-through FIFO. A downstream consumer drains the FIFO over a valid/ready handshake, so results can be written out or compared against a pattern file.

## Interface
- VALUE_W, 5: width of the observed result bus ({co, sum[3:0]}).
- TIME_W, 16: width of the free-running timestamp counter.
- DEPTH, 8: number of FIFO entries; must be a power of 2 and ≥ 2.
- SETTLE, 2: consecutive equal samples required before a value is logged; must be ≥ 1.
- Reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  logging and timestamp enable.
- result  in  VALUE_W  observed DUT result bus.
- clear_ovf  in  1  synchronous clear of the overflow flag.
- rec_valid  out  1  FIFO head is valid.
- rec_ready  in  1  consumer accepts the head entry.
- rec_time  out  TIME_W  timestamp of the head entry.
- rec_value  out  VALUE_W  value of the head entry.
- count  out  $clog2(DEPTH)+1  number of FIFO occupants.
- overflow  out  1  sticky flag: a record was dropped because the FIFO was full.

## Operation
- **Reset.** Reset clears every output to 0. Timer = 0, candidate = 0, stab_cnt = 0, last_logged = 0, first_flag = 1, state = IDLE, FIFO empty.
- **Timer.**
  - Increments by 1 on each edge while enable = 1.
  - Wraps from 2^TIME_W−1 to 0 with no flag.
  - Holds its value while enable = 0.
- **Capture FSM** (all transitions evaluated only while enable = 1):
  - IDLE: sample result into candidate, cand_time ← timer, stab_cnt ← 1, then go to SETTLING. If SETTLE = 1, evaluate the commit condition in the same cycle.
  - SETTLING, result ≠ candidate: reload candidate, cand_time and stab_cnt ← 1; stay in SETTLING (the glitch restarts settling).
  - SETTLING, result = candidate: stab_cnt increments, saturating at SETTLE.
  - Commit condition: stab_cnt reaches SETTLE in this cycle and (candidate ≠ last_logged or first_flag = 1).
    - Push {cand_time, candidate}, last_logged ← candidate, first_flag ← 0.
    - Go to STABLE.
  - If stab_cnt reaches SETTLE but candidate equals last_logged (and first_flag = 0), there is no push; go to STABLE.
  - STABLE, result ≠ candidate: reload candidate, cand_time and stab_cnt ← 1; go to SETTLING.
- **enable = 0.** State is forced to IDLE and any unsettled candidate is discarded. last_logged and first_flag are kept. FIFO draining continues unaffected.
- **FIFO.**
  - First-word-fall-through: rec_time and rec_value show the head whenever rec_valid = 1. They hold their last value when the FIFO is empty.
  - A pop occurs when rec_valid && rec_ready.
  - A push when count = DEPTH succeeds only if a pop happens in the same cycle; count is then unchanged.
  - Otherwise a push into a full FIFO is dropped and overflow ← 1. last_logged still updates.
  - Read and write pointers wrap modulo DEPTH. count distinguishes full from empty.
- **overflow.** Cleared by clear_ovf or reset. If a drop and clear_ovf occur in the same cycle, the drop wins (overflow = 1).

## Timing
- Log latency: a value first sampled at edge E0 and stable through edge E0+SETTLE−1 is pushed at edge E0+SETTLE−1.
  - rec_valid rises after that edge if the FIFO was empty (2 edges for SETTLE = 2).
  - Timestamp = timer value at E0.
- Push-to-visible latency into an empty FIFO: 0 additional cycles (fall-through).
- Pop updates the head on the same edge; the next entry is visible immediately after it.
- rec_valid, count and overflow are registered; there are no combinational paths from result to outputs.
- rec_ready may toggle freely. The producer does not wait on it: there is no backpressure to the capture FSM, and records are dropped when the FIFO is full.

## Test plan
- **Reset and first value.** Release rst_n with enable = 1 and result = 5'h00 held. Required: one record {time 0, value 0x00}; rec_valid rises after edge 1; no further records.
- **Settled change.** At timer = 10, drive result 0x00 → 0x13 and hold. Required: record {10, 0x13}, pushed 2 edges after first sampling.
- **Glitch rejection.** Pulse result to 0x1F for 1 cycle, then return to 0x13. Required: no record. Then change to 0x07 and hold → exactly one record {t, 0x07}.
- **Full and overflow.** Hold rec_ready = 0 and produce 9 distinct settled values with DEPTH = 8. Required:
  - count = 8 and overflow = 1.
  - The 9th record is lost.
  - Draining returns the 8 records in order.
  - clear_ovf drops overflow to 0.
- **Simultaneous push/pop at full and wrap.**
  - Full FIFO with rec_ready = 1 during a commit: count stays 8, overflow stays 0, the new record lands at the tail.
  - Preload the timer near 0xFFFF via enable cycles: record times wrap correctly (0xFFFF, 0x0001).
- **Enable drop and reset mid-operation.**
  - Deassert enable during SETTLING: no record, timer frozen.
  - Assert rst_n low mid-drain: all outputs are 0 immediately, and the FIFO is empty after release.

Source files
------------

// File: rtl/response_logger_if.sv
// Record stream from response_logger to its downstream consumer.
interface response_logger_if #(
  parameter int unsigned VALUE_W = 5,
  parameter int unsigned TIME_W  = 16,
  parameter int unsigned DEPTH   = 8
);
  logic                   rec_valid;
  logic                   rec_ready;
  logic [TIME_W-1:0]      rec_time;
  logic [VALUE_W-1:0]     rec_value;
  logic [$clog2(DEPTH):0] count;

  modport master (output rec_valid, rec_time, rec_value, count, input rec_ready);
  modport slave  (input rec_valid, rec_time, rec_value, count, output rec_ready);
endinterface

// File: rtl/response_logger.sv
// Logs each settled change of the observed result bus as a {timestamp, value}
// record into a first-word-fall-through FIFO drained over valid/ready.
module response_logger #(
  parameter int unsigned VALUE_W = 5,
  parameter int unsigned TIME_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [VALUE_W-1:0] result,
  input  logic               clear_ovf,
  output logic               overflow,
  response_logger_if.master  rec
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned RW = TIME_W + VALUE_W;

  typedef enum logic [1:0] {IDLE, SETTLING, STABLE} state_t;

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   timer_q, timer_d;
  logic [VALUE_W-1:0]  cand_q, cand_d;
  logic [TIME_W-1:0]   cand_time_q, cand_time_d;
  logic [SW-1:0]       stab_q, stab_d;
  logic [VALUE_W-1:0]  last_q, last_d;
  logic                first_q, first_d;
  logic                push;

  logic [RW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                valid_q, valid_d;
  logic [TIME_W-1:0]   head_time_q, head_time_d;
  logic [VALUE_W-1:0]  head_val_q, head_val_d;
  logic                ovf_q, ovf_d;
  logic                pop, full, push_ok, drop;
  logic [RW-1:0]       push_data;

  // Capture FSM: a reload counts as the first stable sample, so SETTLE = 1
  // commits in the same cycle the value is first seen.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cand_d      = cand_q;
    cand_time_d = cand_time_q;
    stab_d      = stab_q;
    last_d      = last_q;
    first_d     = first_q;
    push        = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      stab_d  = '0;
    end else begin
      timer_d = timer_q + 1'b1;
      if (state_q == IDLE || result != cand_q) begin
        cand_d      = result;
        cand_time_d = timer_q;
        stab_d      = SW'(1);
        state_d     = SETTLING;
      end else if (state_q == SETTLING) begin
        stab_d = stab_q + 1'b1;
      end
      if (state_d == SETTLING && stab_d == SW'(SETTLE)) begin
        state_d = STABLE;
        if (first_q || cand_d != last_q) begin
          push    = 1'b1;
          last_d  = cand_d;
          first_d = 1'b0;
        end
      end
    end
  end

  assign push_data = {cand_time_d, cand_d};

  // The head is held in registers so the outputs keep the last entry once
  // the FIFO drains; a write landing on the new read slot bypasses memory.
  always_comb begin
    pop     = valid_q && rec.rec_ready;
    full    = (count_q == CW'(DEPTH));
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    head_time_d = head_time_q;
    head_val_d  = head_val_q;
    if (count_d != '0) begin
      if (push_ok && wptr_q == rptr_d) begin
        {head_time_d, head_val_d} = push_data;
      end else begin
        {head_time_d, head_val_d} = mem_q[rptr_d];
      end
    end
    valid_d = (count_d != '0);
    ovf_d   = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cand_q      <= '0;
      cand_time_q <= '0;
      stab_q      <= '0;
      last_q      <= '0;
      first_q     <= 1'b1;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      head_time_q <= '0;
      head_val_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cand_q      <= cand_d;
      cand_time_q <= cand_time_d;
      stab_q      <= stab_d;
      last_q      <= last_d;
      first_q     <= first_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      head_time_q <= head_time_d;
      head_val_q  <= head_val_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign rec.rec_valid = valid_q;
  assign rec.rec_time  = head_time_q;
  assign rec.rec_value = head_val_q;
  assign rec.count     = count_q;
  assign overflow      = ovf_q;
endmodule
